// File: rtl/cut_tester_pkg.sv
// Shared types, constants and helper functions for the CUT signature tester.
package cut_tester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CLR  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [7:0]  LFSR_SAFE_SEED = 8'h01;
    localparam logic [15:0] MISR_POLY      = 16'h1021;

    // One step of the 8-bit Fibonacci LFSR (taps 7,5,4,3).
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // An all-zero seed would lock the LFSR, so replace it with the safe seed.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? LFSR_SAFE_SEED : s;
    endfunction

    // One MISR compression step: shift, fold the polynomial when the MSB falls out,
    // and XOR in the parallel 8-bit response (modulo 2, no carries).
    function automatic logic [15:0] misr_next(input logic [15:0] cur, input logic [7:0] din);
        logic [15:0] fold;
        fold = cur[15] ? MISR_POLY : 16'h0000;
        return {cur[14:0], 1'b0} ^ fold ^ {8'h00, din};
    endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register with synchronous clear, enable
// and an 8-bit parallel input.
module misr16
    import cut_tester_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] sig
);

    logic [15:0] sig_r;

    // Signature state: clear dominates, otherwise compress din when enabled.
    always_ff @(posedge clk) begin
        if (clear) begin
            sig_r <= 16'h0000;
        end else if (en) begin
            sig_r <= misr_next(sig_r, din);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/cut_signature_tester.sv
// Stimulus/response harness for a circuit-under-test: pulses the CUT clear,
// drives a seeded LFSR vector stream and compresses the CUT response into a
// 16-bit MISR signature.
// Optional build macro CUT_REGISTERED_EN: support a CUT with one cycle of
// registered latency (one extra RUN cycle, MISR skips the first RUN cycle).
module cut_signature_tester
    import cut_tester_pkg::*;
#(
    parameter int unsigned NUM_VECTORS  = 256,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [7:0]  seed,
    output logic        cut_clear,
    output logic [7:0]  cut_input,
    input  logic [7:0]  cut_output,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    localparam logic [3:0]  CLR_LAST = 4'(CLEAR_CYCLES - 1);
    localparam logic [15:0] VEC_LAST = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] VEC_END  = 16'(NUM_VECTORS);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  lfsr_r;
    logic [3:0]  clr_cnt_r;
    logic [15:0] vec_cnt_r;
    logic        start_ok_s;
    logic        run_step_s;
    logic        misr_en_s;
    logic        misr_clr_s;
    logic [7:0]  cut_input_s;
    logic        cut_clear_r;
    logic        busy_r;
    logic        done_r;

    // A start is only honoured while idle or finished.
    assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Next-state decode plus the per-cycle LFSR step and MISR enable strobes.
    always_comb begin
        state_s    = state_r;
        run_step_s = 1'b0;
        misr_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CLR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    state_s = RUN;
                end else begin
                    state_s = CLR;
                end
            end
            RUN: begin
`ifdef CUT_REGISTERED_EN
                // First RUN cycle has no valid response yet; last cycle only drains.
                misr_en_s = (vec_cnt_r != 16'h0000);
                if (vec_cnt_r == VEC_END) begin
                    state_s = DONE;
                end else begin
                    state_s    = RUN;
                    run_step_s = 1'b1;
                end
`else
                misr_en_s  = 1'b1;
                run_step_s = 1'b1;
                if (vec_cnt_r == VEC_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
`endif
            end
            DONE: begin
                if (start) begin
                    state_s = CLR;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // LFSR: loaded from the (lockup-safe) seed on start, stepped once per vector.
    always_ff @(posedge clk) begin
        if (clear) begin
            lfsr_r <= LFSR_SAFE_SEED;
        end else if (start_ok_s) begin
            lfsr_r <= seed_fix(seed);
        end else if (run_step_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Clear-phase cycle counter.
    always_ff @(posedge clk) begin
        if (clear || start_ok_s) begin
            clr_cnt_r <= 4'd0;
        end else if ((state_r == CLR) && (clr_cnt_r != CLR_LAST)) begin
            clr_cnt_r <= clr_cnt_r + 4'd1;
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end

    // Applied-vector counter, saturating at NUM_VECTORS.
    always_ff @(posedge clk) begin
        if (clear || start_ok_s) begin
            vec_cnt_r <= 16'h0000;
        end else if (run_step_s && (vec_cnt_r != VEC_END)) begin
            vec_cnt_r <= vec_cnt_r + 16'h0001;
        end else begin
            vec_cnt_r <= vec_cnt_r;
        end
    end

    // Status and CUT clear are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (clear) begin
            cut_clear_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cut_clear_r <= (state_s == CLR);
            busy_r      <= (state_s == CLR) || (state_s == RUN);
            done_r      <= (state_s == DONE);
        end
    end

    // CUT stimulus: the LFSR value while vectors are being applied, zero otherwise.
    always_comb begin
        cut_input_s = 8'h00;
        if (state_r == RUN) begin
`ifdef CUT_REGISTERED_EN
            if (vec_cnt_r != VEC_END) begin
                cut_input_s = lfsr_r;
            end else begin
                cut_input_s = 8'h00;
            end
`else
            cut_input_s = lfsr_r;
`endif
        end else begin
            cut_input_s = 8'h00;
        end
    end

    assign misr_clr_s = clear || start_ok_s;

    misr16 u_misr (
        .clk   (clk),
        .clear (misr_clr_s),
        .en    (misr_en_s),
        .din   (cut_output),
        .sig   (signature)
    );

    assign cut_clear = cut_clear_r;
    assign cut_input = cut_input_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_cut_signature_tester.sv
// Self-checking bench: three tester instances (2, 1 and 40 vectors) share
// stimulus; a table of seeds/CUT modes drives runs whose expected signatures
// are queued at start and compared at done.
module tb_cut_signature_tester;

`ifdef CUT_REGISTERED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int NC = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear;
    logic        start;
    logic [7:0]  seed;
    logic        zero_cut;

    logic        cc_a, busy_a, done_a, cc_b, busy_b, done_b, cc_c, busy_c, done_c;
    logic [7:0]  ci_a, co_a, ci_b, co_b, ci_c, co_c;
    logic [15:0] sig_a, sig_b, sig_c;

    int n_vec  = 0;
    int n_miss = 0;

    cut_signature_tester #(.NUM_VECTORS(2), .CLEAR_CYCLES(2)) dut_a (
        .clk(clk), .clear(clear), .start(start), .seed(seed), .cut_clear(cc_a),
        .cut_input(ci_a), .cut_output(co_a), .busy(busy_a), .done(done_a), .signature(sig_a));
    cut_signature_tester #(.NUM_VECTORS(1), .CLEAR_CYCLES(2)) dut_b (
        .clk(clk), .clear(clear), .start(start), .seed(seed), .cut_clear(cc_b),
        .cut_input(ci_b), .cut_output(co_b), .busy(busy_b), .done(done_b), .signature(sig_b));
    cut_signature_tester #(.NUM_VECTORS(NC), .CLEAR_CYCLES(2)) dut_c (
        .clk(clk), .clear(clear), .start(start), .seed(seed), .cut_clear(cc_c),
        .cut_input(ci_c), .cut_output(co_c), .busy(busy_c), .done(done_c), .signature(sig_c));

    function automatic logic [7:0] cut_fn(input logic [7:0] v, input logic z);
        return z ? 8'h00 : (v ^ 8'h3C);
    endfunction

`ifdef CUT_REGISTERED_EN
    // Registered CUT models: one cycle of latency.
    always_ff @(posedge clk) begin
        co_a <= cut_fn(ci_a, zero_cut);
        co_b <= cut_fn(ci_b, zero_cut);
        co_c <= cut_fn(ci_c, zero_cut);
    end
`else
    // Combinational CUT models.
    always_comb begin
        co_a = cut_fn(ci_a, zero_cut);
        co_b = cut_fn(ci_b, zero_cut);
        co_c = cut_fn(ci_c, zero_cut);
    end
`endif

    // Reference signature for n vectors from seed s.
    function automatic logic [15:0] model_sig(input logic [7:0] s, input logic z, input int n);
        logic [7:0]  v;
        logic [7:0]  o;
        logic [15:0] g;
        logic        msb;
        v = (s == 8'h00) ? 8'h01 : s;
        g = 16'h0000;
        for (int i = 0; i < n; i++) begin
            o   = cut_fn(v, z);
            msb = g[15];
            g   = {g[14:0], 1'b0} ^ {8'h00, o};
            if (msb) g = g ^ 16'h1021;
            v = {v[6:0], ^(v & 8'hB8)};
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  seed;
        logic        zero;
        logic [15:0] sig_n2;
        logic [15:0] sig_n1;
    } vec_t;

    typedef struct {
        logic [15:0] sa;
        logic [15:0] sb;
        logic [15:0] sc;
    } exp_t;

    vec_t tbl[6];
    exp_t sb_q[$];

    // Launch a run, optionally poke start mid-RUN, then score at done.
    task automatic run_one(input logic [7:0] s, input logic z, input logic poke,
                           input logic [15:0] ea, input logic [15:0] eb);
        int   la, lb, lc;
        exp_t e;
        e.sa = ea;
        e.sb = eb;
        e.sc = model_sig(s, z, NC);
        sb_q.push_back(e);
        la = -1; lb = -1; lc = -1;
        seed = s; zero_cut = z; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; seed = 8'h5A;
        for (int k = 1; k <= 200; k++) begin
            if (done_a && la < 0) la = k;
            if (done_b && lb < 0) lb = k;
            if (done_c && lc < 0) lc = k;
            if (la >= 0 && lb >= 0 && lc >= 0) break;
            if (poke && k == 3) begin
                start = 1'b1; seed = 8'h33;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("latency_n2", 32'(la), 32'(3 + 2 + EXTRA));
        check("latency_n1", 32'(lb), 32'(3 + 1 + EXTRA));
        check("latency_n40", 32'(lc), 32'(3 + NC + EXTRA));
        check("sig_n2", 32'(sig_a), 32'(e.sa));
        check("sig_n1", 32'(sig_b), 32'(e.sb));
        check("sig_n40", 32'(sig_c), 32'(e.sc));
    endtask

    // Cycle-by-cycle trace of the 2-vector instance.
    task automatic trace(input logic [7:0] s, input logic z, input logic [7:0] v1, input logic [7:0] v2);
        logic [7:0] ev;
        seed = s; zero_cut = z; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 5 + EXTRA; k++) begin
            ev = (k == 3) ? v1 : ((k == 4) ? v2 : 8'h00);
            check("trace_cut_clear", 32'(cc_a), 32'(k <= 2));
            check("trace_cut_input", 32'(ci_a), 32'(ev));
            check("trace_done", 32'(done_a), 32'(k == 5 + EXTRA));
            check("trace_busy", 32'(busy_a), 32'(k < 5 + EXTRA));
            @(posedge clk); #1;
        end
        for (int k = 0; k < 100 && !done_c; k++) begin
            @(posedge clk); #1;
        end
        check("trace_drain_done", 32'(done_c), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'({busy_a, busy_b, busy_c}), 32'd0);
        check({tag, "_done"}, 32'({done_a, done_b, done_c}), 32'd0);
        check({tag, "_sig"}, 32'(sig_c), 32'd0);
        check({tag, "_cut_clear"}, 32'({cc_a, cc_c}), 32'd0);
        check({tag, "_cut_input"}, 32'(ci_c), 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'hAA, 1'b0, 16'h0145, 16'h0096};
        tbl[1] = '{8'h00, 1'b1, 16'h0000, 16'h0000};
        tbl[2] = '{8'h00, 1'b0, 16'h0044, 16'h003D};
        tbl[3] = '{8'hFF, 1'b0, 16'h0144, 16'h00C3};
        tbl[4] = '{8'h80, 1'b0, 16'h0145, 16'h00BC};
        tbl[5] = '{8'hAA, 1'b0, 16'h0145, 16'h0096};

        clear = 1'b1; start = 1'b0; seed = 8'h00; zero_cut = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset_init");
        clear = 1'b0;

        trace(8'hAA, 1'b0, 8'hAA, 8'h55);
        check("trace_aa_sig", 32'(sig_a), 32'h0145);
        trace(8'h00, 1'b1, 8'h01, 8'h02);
        check("trace_zero_sig", 32'(sig_a), 32'h0000);

        for (int i = 0; i < 6; i++) begin
            run_one(tbl[i].seed, tbl[i].zero, 1'b0, tbl[i].sig_n2, tbl[i].sig_n1);
        end

        // start pulsed mid-RUN must be ignored; then restart from DONE reproduces.
        run_one(8'hAA, 1'b0, 1'b1, 16'h0145, 16'h0096);
        run_one(8'hAA, 1'b0, 1'b0, 16'h0145, 16'h0096);

        // Clear held three cycles mid-run.
        seed = 8'hC3; zero_cut = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        check("midrun_busy", 32'(busy_c), 32'd1);
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_reset_outputs("midrun_clear");
        end
        // start and clear together: clear wins.
        start = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("clear_beats_start");
        clear = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("idle_after_clear");

        run_one(8'h3C, 1'b0, 1'b0, model_sig(8'h3C, 1'b0, 2), model_sig(8'h3C, 1'b0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
